seq_match_event_logger: RTL and testbench
=========================================

// Module: seq_match_event_logger
// PURPOSE
//  Downstream consumer of the serial sequence detector's Mealy match output.
//  - Tracks the index of every serial bit; logs the index of each bit on which a
//    match was flagged into a small first-word-fall-through (FWFT) FIFO.
//  - Keeps a saturating match count; pulses a threshold flag for software/polling.
//  - Sits between the detector and the register/readout logic.
// PARAMETERS
//  POS_W   16  width of bit-position counter and of logged entries
//  CNT_W   8   width of saturating match counter
//  DEPTH   4   FIFO entries; power of 2, >=2
//  THRESH  4   match count at which thresh_hit pulses; 1..2^CNT_W-1
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  bit_valid   in   1      detector consumes a serial bit this cycle
//  match       in   1      detector Mealy output for that bit; qualified by bit_valid
//  clear       in   1      synchronous soft clear (same effect as reset)
//  rd_en       in   1      pop FIFO head
//  rd_data     out  POS_W  FIFO head (FWFT); 0 when empty
//  empty       out  1      FIFO empty
//  full        out  1      FIFO holds DEPTH entries
//  overflow    out  1      sticky: an event was dropped because FIFO was full
//  match_cnt   out  CNT_W  saturating count of accepted match events
//  thresh_hit  out  1      one-cycle pulse when match_cnt becomes THRESH
// BEHAVIOUR
//  - Reset/clear values:
//    - pos=0, FIFO emptied: empty=1, full=0, rd_data=0.
//    - overflow=0, match_cnt=0, thresh_hit=0.
//    - clear and reset have priority over every same-cycle event; that cycle's
//      bit/match/rd_en is discarded.
//  - Position counter pos:
//    - +1 on each bit_valid cycle; wraps 2^POS_W-1 -> 0 silently.
//    - First bit after reset has index 0.
//  - Event:
//    - event = bit_valid & match; match with bit_valid=0 is ignored.
//    - Logged value = pos of that same bit (value before the increment).
//  - Push/pop:
//    - Push on event when not full.
//    - Pop on rd_en & !empty; rd_en while empty is ignored (no underflow, no flag).
//    - Push and pop in the same cycle: both occur, occupancy unchanged; legal when
//      full (entry accepted) and when empty with 0 occupancy (pop ignored, push
//      occurs).
//    - Event while full with no same-cycle pop: entry dropped, overflow<=1 and held
//      until reset/clear.
//  - Latency:
//    - Pushed entry visible on rd_data, empty=0, the cycle after the push edge.
//    - After a pop, rd_data shows the next entry the following cycle.
//    - full and empty are registered, exact occupancy flags (occupancy 0..DEPTH).
//  - Counter and threshold:
//    - match_cnt +1 per event, including dropped ones; saturates at 2^CNT_W-1 (no
//      wrap).
//    - thresh_hit=1 for exactly the cycle after the edge at which match_cnt goes
//      THRESH-1 -> THRESH.
//    - thresh_hit does not re-fire while saturated or static; fires again only after
//      reset/clear.
//  - Storage: FIFO pointers are log2(DEPTH) bits, wrap naturally; occupancy counter
//    is log2(DEPTH)+1 bits.
// TESTING
//  1 Reset: hold reset 2 cycles with bit_valid=match=1
//    -> empty=1, match_cnt=0, overflow=0, thresh_hit=0.
//  2 Stream 1101101 (bit_valid every cycle), match high on bits 3 and 6
//    -> rd_data=3 then 6 on successive pops; match_cnt=2.
//  3 DEPTH=4: 5 events with no pops
//    -> full=1 after 4th; 5th dropped, overflow=1, match_cnt=5; pops return first 4
//       indices in order.
//  4 Full FIFO, event and rd_en in same cycle
//    -> occupancy stays 4, head advances, overflow stays 0.
//  5 Counter/threshold: THRESH=4, CNT_W=3, 9 events
//    -> thresh_hit single pulse after 4th; match_cnt saturates at 7.
//  6 Edge cases:
//    - match=1 with bit_valid=0 -> no event.
//    - clear mid-stream, coinciding with an event -> event discarded; next bit
//      logged index 0.
//    - POS_W=4: 17 bits -> pos wraps; bit 16 logs index 0.

Source files
------------

// File: rtl/seq_match_event_logger.sv
// seq_match_event_logger: logs the bit index of each detector match into a
// small FWFT FIFO. It also keeps a saturating match count with a one-shot
// threshold pulse. Reset and clear are both synchronous and override every
// same-cycle event.
module seq_match_event_logger #(
  parameter int POS_W  = 16,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4,
  parameter int THRESH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             bit_valid_i,
  input  logic             match_i,
  input  logic             clear_i,
  input  logic             rd_en_i,
  output logic [POS_W-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             thresh_hit_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(THRESH - 1);
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ovf_q, ovf_d, thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill, evt, push, pop;

  // Event qualification. A pop frees a slot in the same cycle, so a full FIFO still accepts an event when it is read at the same time.
  always_comb begin
    kill = reset_i | clear_i;
    evt  = bit_valid_i & match_i;
    pop  = rd_en_i & ~empty_q;
    push = evt & (~full_q | pop);
  end

  // Next-state computation for the position, the pointers, the flags and the counter.
  always_comb begin
    pos_d    = bit_valid_i ? pos_q + POS_W'(1) : pos_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d   = (occ_d == OCC_FULL);
    empty_d  = (occ_d == '0);
    ovf_d    = ovf_q | (evt & full_q & ~pop);
    cnt_d    = (evt && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    // The pulse only fires on the THRESH-1 -> THRESH step. The counter never returns to that step without a reset or clear.
    thr_d    = evt && (cnt_q == CNT_PRE);
  end

  // State registers; reset and clear discard the whole cycle.
  always_ff @(posedge clk_i) begin
    if (kill) begin
      pos_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      thr_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
    end
  end

  // FIFO storage. Contents need no reset because rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!kill && push) mem_q[wr_ptr_q] <= pos_q;
  end

  // Outputs. The head is shown first-word-fall-through and reads zero when the FIFO is empty.
  always_comb begin
    rd_data_o    = empty_q ? '0 : mem_q[rd_ptr_q];
    empty_o      = empty_q;
    full_o       = full_q;
    overflow_o   = ovf_q;
    match_cnt_o  = cnt_q;
    thresh_hit_o = thr_q;
  end

endmodule

// File: tb/tb_seq_match_event_logger.sv
// Randomized and directed bench for seq_match_event_logger. The reference model is a queue of logged indices plus integer counters.
module tb_seq_match_event_logger;

  localparam int POS_W  = 4;
  localparam int CNT_W  = 3;
  localparam int DEPTH  = 4;
  localparam int THRESH = 4;

  logic             clk = 1'b0;
  logic             reset, bit_valid, match, clear, rd_en;
  logic [POS_W-1:0] rd_data;
  logic             empty, full, overflow, thresh_hit;
  logic [CNT_W-1:0] match_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_q[$];
  int m_pos, m_cnt;
  bit m_ovf, m_thr;

  always #5 clk = ~clk;

  seq_match_event_logger #(.POS_W(POS_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk_i(clk), .reset_i(reset), .bit_valid_i(bit_valid), .match_i(match),
    .clear_i(clear), .rd_en_i(rd_en), .rd_data_o(rd_data), .empty_o(empty),
    .full_o(full), .overflow_o(overflow), .match_cnt_o(match_cnt),
    .thresh_hit_o(thresh_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare every output.
  task automatic cyc(input bit r, input bit bv, input bit m, input bit rd, input bit cl);
    bit full_before, popped;
    reset = r; bit_valid = bv; match = m; rd_en = rd; clear = cl;
    @(posedge clk);
    if (r || cl) begin
      m_q.delete(); m_pos = 0; m_ovf = 0; m_cnt = 0; m_thr = 0;
    end else begin
      m_thr       = 0;
      full_before = (m_q.size() == DEPTH);
      popped      = rd && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (bv && m) begin
        if (!full_before || popped) m_q.push_back(m_pos);
        else m_ovf = 1;
        if (m_cnt < (1 << CNT_W) - 1) begin
          m_cnt++;
          if (m_cnt == THRESH) m_thr = 1;
        end
      end
      if (bv) m_pos = (m_pos + 1) % (1 << POS_W);
    end
    #1;
    chk("rd_data",    32'(rd_data),    (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("empty",      32'(empty),      32'(m_q.size() == 0));
    chk("full",       32'(full),       32'(m_q.size() == DEPTH));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("match_cnt",  32'(match_cnt),  32'(m_cnt));
    chk("thresh_hit", 32'(thresh_hit), 32'(m_thr));
  endtask

  initial begin
    reset = 1; bit_valid = 0; match = 0; clear = 0; rd_en = 0;
    m_pos = 0; m_cnt = 0; m_ovf = 0; m_thr = 0;
    // Test 1: reset is held for 2 cycles while a bit and a match are presented.
    repeat (2) cyc(1, 1, 1, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_cnt",   32'(match_cnt), 32'd0);

    // Test 2: the stream 1101101 is sent with match on bits 3 and 6. Both indices are then popped.
    for (int i = 0; i < 7; i++) cyc(0, 1, (i == 3 || i == 6), 0, 0);
    chk("t2_head3", 32'(rd_data), 32'd3);
    chk("t2_cnt",   32'(match_cnt), 32'd2);
    cyc(0, 0, 0, 1, 0);
    chk("t2_head6", 32'(rd_data), 32'd6);
    cyc(0, 0, 0, 1, 0);

    // Test 3: five events are sent with no pops. The fifth is dropped and overflow is set.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf",  32'(overflow), 32'd1);
    chk("t3_cnt",  32'(match_cnt), 32'd5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

    // Test 4: the FIFO is full and an event and a pop happen in the same cycle.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_head", 32'(rd_data), 32'd1);
    chk("t4_ovf",  32'(overflow), 32'd0);

    // Test 5: nine events are sent with pops running. The threshold pulse fires once and the counter saturates at 7.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 1, 0);
    chk("t5_sat", 32'(match_cnt), 32'd7);

    // Test 6: match without bit_valid is ignored. A clear that coincides with an event discards it. Then the position wraps.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk("t6_nobv", 32'(empty), 32'd1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 0);
    chk("t6_clr0", 32'(rd_data), 32'd0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1, (i == 15 || i == 16), 0, 0);
    chk("t6_w15", 32'(rd_data), 32'd15);
    cyc(0, 0, 0, 1, 0);
    chk("t6_w0",  32'(rd_data), 32'd0);

    // Random phase: the read rate varies per phase so that full, overflow and empty are all reached.
    for (int ph = 0; ph < 8; ph++) begin
      int rd_pct = (ph % 4) * 30;
      for (int i = 0; i < 250; i++)
        cyc(($urandom % 400) == 0, ($urandom % 4) != 0, $urandom % 2,
            ($urandom % 100) < rd_pct, ($urandom % 150) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
